// File: rtl/delay_pkg.sv
// Shared widths, output-select encoding and delay clamping for the delay_core slice.
// Pure declarations; no logic of its own.
package delay_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;
    localparam int MOD_W_DEF  = 16;

    typedef enum logic [1:0] {
        OUT_ZERO = 2'd0,
        OUT_RAM  = 2'd1,
        OUT_BYP  = 2'd2
    } out_sel_e;

    // Clamp a signed delay sum into [1, depth-1]; caller truncates to ADDR_W bits.
    function automatic logic [31:0] clamp_delay(input logic signed [31:0] sum, input int depth);
        logic [31:0] d;
        if (sum < 32'sd1) begin
            d = 32'd1;
        end else if (sum > (depth - 1)) begin
            d = 32'(depth - 1);
        end else begin
            d = $unsigned(sum);
        end
        return d;
    endfunction

endpackage

// File: rtl/delay_ram.sv
// Simple dual-port RAM, DEPTH x DATA_W, synchronous write and read-first synchronous read.
// Latency: read data valid one cycle after rd_en.
// No backpressure: a port is idle whenever its enable is low, rd_dat holds.
module delay_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/delay_core.sv
// Audio delay line: dout = din delayed by clamp(base_delay + mod_val, 1, DEPTH-1), or registered bypass.
// Latency: D enabled cycles on the delayed path, 1 cycle in bypass. Option macro: DELAY_CORE_OUT_MASK_EN.
// No backpressure: en=0 freezes write pointer, buffer and output.
module delay_core
    import delay_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int MOD_W  = MOD_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     bypass,
    input  logic        [ADDR_W-1:0] base_delay,
    input  logic signed [MOD_W-1:0]  mod_val,
    input  logic signed [DATA_W-1:0] din,
    output logic signed [DATA_W-1:0] dout
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int SUM_W = ((ADDR_W + 1 > MOD_W) ? ADDR_W + 1 : MOD_W) + 1;

    logic signed [SUM_W-1:0]  sum;
    logic        [ADDR_W-1:0] d;
    logic        [ADDR_W-1:0] wr_ptr;
    logic        [ADDR_W-1:0] rd_addr;
    logic        [DATA_W-1:0] ram_q;
    logic signed [DATA_W-1:0] byp_dat;
    logic                     hist_ok;
    out_sel_e                 out_sel;

    assign sum     = SUM_W'($signed({1'b0, base_delay})) + SUM_W'(mod_val);
    assign d       = ADDR_W'(clamp_delay(32'(sum), DEPTH));
    assign rd_addr = wr_ptr - d;

`ifdef DELAY_CORE_OUT_MASK_EN
    logic [ADDR_W-1:0] fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill <= '0;
        end else if (en && (fill != {ADDR_W{1'b1}})) begin
            fill <= fill + 1'b1;
        end
    end

    // Reading a slot not yet written since reset would replay stale pre-reset audio.
    assign hist_ok = (fill >= d);
`else
    assign hist_ok = 1'b1;
`endif

    delay_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (en),
        .wr_addr (wr_ptr),
        .wr_dat  (din),
        .rd_en   (en),
        .rd_addr (rd_addr),
        .rd_dat  (ram_q)
    );

    // RAM read register doubles as the delayed output register; out_sel picks the source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            byp_dat <= '0;
            out_sel <= OUT_ZERO;
        end else if (en) begin
            wr_ptr  <= wr_ptr + 1'b1;
            byp_dat <= din;
            if (bypass) begin
                out_sel <= OUT_BYP;
            end else if (hist_ok) begin
                out_sel <= OUT_RAM;
            end else begin
                out_sel <= OUT_ZERO;
            end
        end
    end

    always_comb begin
        dout = '0;
        case (out_sel)
            OUT_RAM: dout = $signed(ram_q);
            OUT_BYP: dout = byp_dat;
            default: dout = '0;
        endcase
    end

endmodule

// File: tb/tb_delay_core.sv
// Directed self-checking bench for delay_core with a sample-history reference.
module tb_delay_core;

    logic               clk;
    logic               rst_n;
    logic               en;
    logic               bypass;
    logic        [7:0]  base_delay;
    logic signed [15:0] mod_val;
    logic signed [15:0] din;
    logic signed [15:0] dout;

    int nvec;
    int nerr;
    int widx;
    logic signed [15:0] hist [0:4095];
    logic signed [15:0] prev_exp;

    delay_core dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .bypass     (bypass),
        .base_delay (base_delay),
        .mod_val    (mod_val),
        .din        (din),
        .dout       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampd(input int s);
        if (s < 1) return 1;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive x, predict dout from the sample history, optionally compare.
    task automatic cycle(input logic signed [15:0] x, input string tag, input bit chk_on);
        int dd;
        logic signed [15:0] exp;
        din = x;
        dd  = clampd(int'(base_delay) + int'(mod_val));
        if (en) begin
            if (bypass)            exp = x;
            else if (widx - dd >= 0) exp = hist[widx - dd];
            else                   exp = 16'sd0;
        end else begin
            exp = prev_exp;
        end
        @(posedge clk);
        #1;
        if (en) begin
            hist[widx] = x;
            widx++;
        end
        if (chk_on) chk(tag, 32'(dout), 32'(exp));
        prev_exp = exp;
    endtask

    function automatic logic signed [15:0] stale_at(input int a, input int oldw);
        for (int k = oldw - 1; k >= 0; k--) begin
            if ((k % 256) == a) return hist[k];
        end
        return 16'sd0;
    endfunction

    initial begin
        int oldw;
        int w0;
        logic signed [15:0] held;
        logic signed [15:0] stale;
        logic signed [15:0] first_post;
        nvec = 0;
        nerr = 0;
        widx = 0;
        prev_exp = 16'sd0;
        for (int i = 0; i < 4096; i++) hist[i] = 16'sd0;
        rst_n = 1'b0; en = 1'b0; bypass = 1'b0;
        base_delay = 8'd50; mod_val = 16'sd0; din = 16'sd0;

        #2;
        chk("reset_dout", 32'(dout), 32'sd0);
        chk("reset_wr_ptr", 32'(dut.wr_ptr), 32'sd0);

        // Zero the buffer, then reset so the history model starts clean.
        #10 rst_n = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 256; i++) cycle(16'sd0, "prefill", 1'b0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        widx = 0;
        prev_exp = 16'sd0;
        chk("reset2_dout", 32'(dout), 32'sd0);
        chk("reset2_wr_ptr", 32'(dut.wr_ptr), 32'sd0);

        // Impulse through D=50.
        for (int i = 0; i < 60; i++) cycle(16'sd0, "pre_impulse", 1'b1);
        cycle(16'sd10000, "impulse_cap", 1'b1);
        for (int j = 1; j <= 60; j++) begin
            cycle(16'sd0, "impulse_run", 1'b0);
            chk("impulse", 32'(dout), (j == 50) ? 32'sd10000 : 32'sd0);
        end

        // Sine at D=50.
        for (int i = 0; i < 100; i++) begin
            cycle(16'($rtoi(8000.0 * $sin(2.0 * 3.14159265358979 * 0.05 * i))), "sine", 1'b1);
        end

        // Triangle modulation 0 -> +50 -> -50 -> 0.
        for (int i = 0; i < 200; i++) begin
            if (i < 50)       mod_val = 16'(i);
            else if (i < 150) mod_val = 16'(100 - i);
            else              mod_val = 16'(i - 200);
            cycle(16'(i * 37 - 3000), "mod", 1'b1);
        end
        mod_val = 16'sd0;

        // Clamp low: 50-100 -> D=1.
        mod_val = -16'sd100;
        for (int i = 0; i < 3; i++) cycle(16'sd0, "clamp_lo_pre", 1'b1);
        cycle(16'sd20000, "clamp_lo_cap", 1'b1);
        cycle(16'sd0, "clamp_lo_run", 1'b0);
        chk("clamp_lo", 32'(dout), 32'sd20000);
        cycle(16'sd0, "clamp_lo_run", 1'b0);
        chk("clamp_lo_after", 32'(dout), 32'sd0);

        // Clamp high: 200+200 -> D=255.
        base_delay = 8'd200;
        mod_val = 16'sd200;
        for (int i = 0; i < 20; i++) cycle(16'(1000 + 11 * i), "clamp_hi", 1'b1);

        // Bypass, then history written during bypass at D=3.
        base_delay = 8'd3;
        mod_val = 16'sd0;
        bypass = 1'b1;
        cycle(16'sd5000, "byp_cap", 1'b0);
        chk("bypass_5000", 32'(dout), 32'sd5000);
        cycle(16'sd0, "byp", 1'b0);
        chk("bypass_0", 32'(dout), 32'sd0);
        cycle(16'sd700, "byp", 1'b0);
        chk("bypass_700", 32'(dout), 32'sd700);
        bypass = 1'b0;
        cycle(16'sd0, "post_byp", 1'b0);
        chk("post_bypass_5000", 32'(dout), 32'sd5000);
        cycle(16'sd0, "post_byp", 1'b0);
        chk("post_bypass_0", 32'(dout), 32'sd0);
        cycle(16'sd0, "post_byp", 1'b0);
        chk("post_bypass_700", 32'(dout), 32'sd700);

        // en=0 freeze with changing din.
        for (int i = 0; i < 5; i++) cycle(16'(-200 * i - 1), "pre_freeze", 1'b1);
        held = prev_exp;
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(16'(31000 - i), "freeze_run", 1'b0);
            chk("freeze_dout", 32'(dout), 32'(held));
            chk("freeze_wr_ptr", 32'(dut.wr_ptr), 32'(widx % 256));
        end
        en = 1'b1;
        for (int i = 0; i < 6; i++) cycle(16'(77 * i), "thaw", 1'b1);

        // Asynchronous reset mid-stream.
        base_delay = 8'd5;
        for (int i = 0; i < 8; i++) cycle(16'(123 + i), "pre_rst", 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_dout", 32'(dout), 32'sd0);
        chk("async_rst_wr_ptr", 32'(dut.wr_ptr), 32'sd0);
        #1 rst_n = 1'b1;
        oldw = widx;
        stale = stale_at(251, oldw);
        w0 = oldw;
        first_post = 16'sd4321;
        for (int i = 0; i < 6; i++) begin
            cycle((i == 0) ? first_post : 16'(i), "post_rst", 1'b0);
`ifdef DELAY_CORE_OUT_MASK_EN
            if (i < 5) chk("mask_zero", 32'(dout), 32'sd0);
`else
            if (i == 0) chk("stale_read", 32'(dout), 32'(stale));
`endif
            if (i == 5) chk("post_rst_first", 32'(dout), 32'(first_post));
        end
        if (w0 < 0) chk("unreachable", 32'(dout), 32'sd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/delay_core.md
Name: delay_core

Overview:
Integer-sample audio delay line built on a circular buffer of 2^ADDR_W words. The effective delay is `base_delay` plus a signed modulation term (LFO/vibrato/chorus input), clamped to the buffer's valid range. A registered bypass path passes the input straight through. The block sits in the audio datapath, one sample per enabled clock.

Parameters:
- DATA_W, 16: sample width, signed two's complement.
- ADDR_W, 8: buffer address width; DEPTH = 2^ADDR_W words.
- MOD_W, 16: modulation input width, signed.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sample enable; one sample is consumed/produced per cycle with en=1.
- bypass  in  1  1 = dout follows din; 0 = delayed output.
- base_delay  in  ADDR_W  unsigned base delay in samples.
- mod_val  in  MOD_W  signed delay offset in samples.
- din  in  DATA_W  signed input sample.
- dout  out  DATA_W  signed output sample, registered.

Behaviour:
- Reset (async assert, sync release): dout=0, wr_ptr=0. Buffer RAM is not cleared by reset; RAM power-up/initial contents are all zero.
- Delay arithmetic:
  - sum = zero-extended base_delay + sign-extended mod_val, computed in max(ADDR_W+1, MOD_W)+1 bits; no overflow is possible.
  - D = clamp(sum, 1, DEPTH-1). Negative or zero sum gives D=1; sum ≥ DEPTH gives DEPTH-1.
  - D is combinational from the current inputs and is used on the same edge.
- Read address: rd_addr = (wr_ptr - D) mod DEPTH, using natural ADDR_W-bit wrap. D≥1 guarantees rd_addr ≠ wr_ptr, so there is never a same-address read/write.
- Each rising edge with en=1:
  - mem[wr_ptr] <= din.
  - wr_ptr <= wr_ptr+1, wrapping DEPTH-1→0.
  - dout <= bypass ? din : mem[rd_addr]. The read returns pre-edge contents.
- Latency: a sample captured at edge n appears on dout after edge n+D (exactly D cycles) when bypass=0 and D is constant. With bypass=1, latency is 1 cycle.
- Buffer writes continue during bypass, so leaving bypass immediately yields correctly delayed history.
- en=0: no write, wr_ptr holds, dout holds its value. Bypass is also gated by en.
- Changing base_delay/mod_val mid-stream: output jumps to the sample at the new offset on the next enabled edge. No interpolation or smoothing; repeated or skipped samples are acceptable.
- Reset mid-operation: dout→0 and wr_ptr→0 immediately. Stale RAM data may emerge afterwards (see optional feature).
- No saturation of sample values: dout is always an exact past din value, or 0.

Optional Feature:
- Macro: DELAY_CORE_OUT_MASK_EN.
- Defined:
  - Adds an ADDR_W-bit fill counter, cleared by reset and incremented on each enabled write, saturating at DEPTH-1.
  - While fill < D, the delayed output is forced to 0, so no stale pre-reset data is emitted.
  - Bypass is unaffected.
- Undefined: no counter; delayed output reads RAM unconditionally.

Decomposition:
- Package delay_pkg:
  - Default width constants DATA_W_DEF=16, ADDR_W_DEF=8, MOD_W_DEF=16.
  - Function clamp_delay(sum, DEPTH) returning the ADDR_W-bit D.
- One natural sub-module: delay_ram, a simple dual-port RAM with sync write and sync read (read-first), DEPTH×DATA_W, inferable as block RAM.
- delay_core holds the pointer, delay arithmetic, bypass mux and output register.

Test Plan:
1. Impulse, base_delay=50, mod_val=0, bypass=0: din=10000 for one cycle, then 0 → dout=10000 on exactly the 50th edge after capture, 0 on every other cycle.
2. Sine, amplitude 8000, 0.05 cycles/sample, 100 samples, base_delay=50 → dout equals din from 50 cycles earlier, bit-exact, no X.
3. Modulation, base_delay=50, mod_val triangle 0→+50→-50→0 over 200 cycles → every dout equals din[n-D(n)] with D=clamp(50+mod_val,1,255); D=100 at peak, D=1 at trough (sum 0 clamps).
4. Clamping:
   - base_delay=50, mod_val=-100, din=20000 impulse → dout=20000 one cycle later (D=1).
   - base_delay=200, mod_val=+200 → D=255.
5. Bypass=1: din=5000 for one cycle → dout=5000 on the next edge, then 0. After bypass returns to 0, delayed output reflects samples written during bypass.
6. Control and reset:
   - en=0 for 10 cycles mid-stream → dout and wr_ptr frozen.
   - rst_n pulse asynchronously mid-stream → dout=0 before the next edge.
   - With DELAY_CORE_OUT_MASK_EN defined, dout stays 0 for the first D enabled cycles after reset.
